player_jump_ctrl: RTL and testbench
===================================

Name: player_jump_ctrl

Overview:
- Frame-rate motion controller for the player box in the Space-Is-Key game.
- Sequences the box's X/Y coordinates through idle, run, jump-arc and death states, driven by a single key plus a collision flag.
- Positions update once per frame-tick pulse and feed the box renderer's coordinate inputs directly.
- Replaces free up/down/left/right counters with game physics: constant X scroll, gravity-driven Y.

Parameters:
- pA, 10, coordinate width in bits (matches the renderer).
- X_START, 0, X after reset and restart.
- X_MAX, 620, largest legal X.
- X_STEP, 2, X advance per frame tick in RUN/AIR.
- GROUND_Y, 220, resting Y (screen Y grows downward).
- JUMP_V, 12, initial upward velocity in pixels/frame.
- GRAV, 1, velocity decrement per frame.
- MAX_FALL, 12, magnitude limit on downward velocity.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse once per video frame.
- jump_key  in  1  key level, active-high, already synchronised.
- collide  in  1  collision level from the obstacle logic; sampled only on frame_tick.
- player_x  out  pA  box X coordinate.
- player_y  out  pA  box Y coordinate.
- state  out  2  IDLE=00, RUN=01, AIR=10, DEAD=11.
- dead  out  1  high while in DEAD.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, player_x=X_START, player_y=GROUND_Y, dead=0.
  - Internal: vel=0, key_q=0, press_pend=0.
  - Reset overrides every other event, including a coincident frame_tick.
- Edge detect:
  - key_q registers jump_key each cycle; press = jump_key & ~key_q.
  - press sets press_pend.
  - press_pend clears on every frame_tick, whether consumed or discarded.
  - A press in the same cycle as frame_tick counts for that tick.
- Timing:
  - All position, velocity and state updates occur only on frame_tick cycles; outputs hold otherwise.
  - Latency: outputs are registered and change one clk after the frame_tick cycle.
- vel is signed, width 8; positive means upward.
- Y arithmetic uses a signed pA+2 intermediate, so no unsigned wrap.
- IDLE: on tick with pend -> RUN. Position unchanged.
- RUN, on tick, highest priority first:
  1. collide -> DEAD, position frozen.
  2. pend -> AIR with vel=JUMP_V; Y unchanged this tick.
  3. Otherwise stay in RUN.
  - X advances in every non-DEAD outcome.
- X advance rule: if player_x + X_STEP > X_MAX, X wraps to X_START; else player_x += X_STEP.
- AIR, on tick:
  - Compute y_n = player_y - vel.
  - Priority: collide -> DEAD (no Y update).
  - Else if y_n >= GROUND_Y: player_y=GROUND_Y, vel=0, state -> RUN (landing).
  - Else if y_n < 0: player_y=0, vel=0 (ceiling clamp).
  - Else: player_y=y_n, then vel = max(vel - GRAV, -MAX_FALL).
  - X advances in AIR.
  - A pend in AIR is discarded (but see DOUBLE_JUMP_EN).
- DEAD:
  - dead=1; X, Y and vel frozen.
  - On tick with pend -> IDLE, X=X_START, Y=GROUND_Y, vel=0.
- collide is ignored in IDLE and DEAD.

Optional Feature:
- Macro: DOUBLE_JUMP_EN.
- Defined:
  - A 1-bit air_jump_used flag is added.
  - In AIR, a tick with pend, no collide and no landing sets vel=JUMP_V and air_jump_used=1; Y updates with the old vel that tick.
  - Further presses are discarded until the flag clears.
  - The flag clears on landing, on reset and on entry to IDLE.
- Undefined: the flag and its logic are absent; presses in AIR are always discarded.

Test Plan:
- Reset: hold rst 2 cycles with frame_tick high -> state=00, X=0, Y=220, dead=0 after release.
- Start and scroll: press, then 3 ticks -> RUN after tick 1; X=2, 4 after ticks 2 and 3 (X unchanged on the IDLE->RUN tick); Y stays 220.
- Full arc (defaults):
  - Press in RUN, then tick -> AIR with Y=220.
  - AIR tick 1 -> Y=208; tick 12 -> Y=142 (apex); tick 13 -> Y=142; tick 14 -> Y=143.
  - Tick 25 -> Y=220, state=RUN.
- Wrap: X=620 in RUN, tick -> X=0.
- Collision priority:
  - In AIR with collide=1 and a press on the same tick -> DEAD, X/Y frozen, dead=1.
  - Next press + tick -> IDLE, X=0, Y=220.
- Mid-air press:
  - Without DOUBLE_JUMP_EN: press at AIR tick 5 leaves the arc unchanged.
  - With DOUBLE_JUMP_EN: vel reloads to 12 on that tick; a second mid-air press is ignored; landing re-arms the flag.

Source files
------------

// File: rtl/player_jump_ctrl.sv
// rtl/player_jump_ctrl.sv - frame-rate player box motion controller (optional feature macro: DOUBLE_JUMP_EN)
module player_jump_ctrl #(
    parameter int pA       = 10,
    parameter int X_START  = 0,
    parameter int X_MAX    = 620,
    parameter int X_STEP   = 2,
    parameter int GROUND_Y = 220,
    parameter int JUMP_V   = 12,
    parameter int GRAV     = 1,
    parameter int MAX_FALL = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          jump_key,
    input  logic          collide,
    output logic [pA-1:0] player_x,
    output logic [pA-1:0] player_y,
    output logic [1:0]    state,
    output logic          dead
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_AIR  = 2'b10,
        S_DEAD = 2'b11
    } state_t;

    localparam logic signed [7:0]    JUMP_VEL = 8'(JUMP_V);
    localparam logic signed [7:0]    GRAV_VEL = 8'(GRAV);
    localparam logic signed [7:0]    VEL_MIN  = 8'(-MAX_FALL);
    localparam logic signed [pA+1:0] GROUND_S = (pA+2)'(GROUND_Y);

    state_t                 state_q, state_d;
    logic [pA-1:0]          x_q, x_d;
    logic [pA-1:0]          y_q, y_d;
    logic signed [7:0]      vel_q, vel_d;
    logic                   key_q;
    logic                   pend_q, pend_d;
    logic                   press;
    logic                   pend;
    logic [pA:0]            x_sum;
    logic [pA-1:0]          x_adv;
    logic signed [pA+1:0]   y_ext;
    logic signed [pA+1:0]   vel_ext;
    logic signed [pA+1:0]   y_n;
    logic signed [7:0]      vel_dec;
`ifdef DOUBLE_JUMP_EN
    logic                   used_q, used_d;
`endif

    // A press coincident with the tick counts for that tick.
    assign press  = jump_key & ~key_q;
    assign pend   = pend_q | press;
    assign pend_d = frame_tick ? 1'b0 : pend;

    // X scroll with wrap back to the start column.
    assign x_sum = {1'b0, x_q} + (pA+1)'(X_STEP);
    assign x_adv = (x_sum > (pA+1)'(X_MAX)) ? pA'(X_START) : x_sum[pA-1:0];

    // Signed Y step, two guard bits so neither overshoot direction wraps.
    assign y_ext   = {2'b00, y_q};
    assign vel_ext = {{(pA-6){vel_q[7]}}, vel_q};
    assign y_n     = y_ext - vel_ext;
    assign vel_dec = vel_q - GRAV_VEL;

    assign player_x = x_q;
    assign player_y = y_q;
    assign state    = state_q;
    assign dead     = (state_q == S_DEAD);

    // State, position, velocity and key-edge registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= pA'(X_START);
            y_q     <= pA'(GROUND_Y);
            vel_q   <= '0;
            key_q   <= 1'b0;
            pend_q  <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            used_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            key_q   <= jump_key;
            pend_q  <= pend_d;
`ifdef DOUBLE_JUMP_EN
            used_q  <= used_d;
`endif
        end
    end

    // Per-frame physics and state transitions; everything holds between ticks.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vel_d   = vel_q;
`ifdef DOUBLE_JUMP_EN
        used_d  = used_q;
`endif
        if (frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (pend) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (collide) begin
                        state_d = S_DEAD;
                    end else begin
                        x_d = x_adv;
                        if (pend) begin
                            state_d = S_AIR;
                            vel_d   = JUMP_VEL;
                        end
                    end
                end
                S_AIR: begin
                    if (collide) begin
                        state_d = S_DEAD;
                    end else begin
                        x_d = x_adv;
                        if (y_n >= GROUND_S) begin
                            state_d = S_RUN;
                            y_d     = pA'(GROUND_Y);
                            vel_d   = '0;
`ifdef DOUBLE_JUMP_EN
                            used_d  = 1'b0;
`endif
                        end else begin
                            if (y_n[pA+1]) begin
                                y_d   = '0;
                                vel_d = '0;
                            end else begin
                                y_d   = y_n[pA-1:0];
                                vel_d = (vel_dec < VEL_MIN) ? VEL_MIN : vel_dec;
                            end
`ifdef DOUBLE_JUMP_EN
                            if (pend && !used_q) begin
                                vel_d  = JUMP_VEL;
                                used_d = 1'b1;
                            end
`endif
                        end
                    end
                end
                S_DEAD: begin
                    if (pend) begin
                        state_d = S_IDLE;
                        x_d     = pA'(X_START);
                        y_d     = pA'(GROUND_Y);
                        vel_d   = '0;
`ifdef DOUBLE_JUMP_EN
                        used_d  = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_jump_ctrl.sv
// tb/tb_player_jump_ctrl.sv - scoreboard testbench for player_jump_ctrl
module tb_player_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       jump_key = 1'b0;
    logic       collide = 1'b0;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [1:0] state;
    logic       dead;

    player_jump_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .jump_key   (jump_key),
        .collide    (collide),
        .player_x   (player_x),
        .player_y   (player_y),
        .state      (state),
        .dead       (dead)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    st;
        int    x;
        int    y;
        int    dd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    int   m_st, m_x, m_y, m_v;
    bit   m_pend, m_used;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_model(input string tag);
        sb.push_back('{tag, m_st, m_x, m_y, (m_st == 3) ? 1 : 0});
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_state"}, int'(state), e.st);
            check({e.tag, "_x"}, int'(player_x), e.x);
            check({e.tag, "_y"}, int'(player_y), e.y);
            check({e.tag, "_dead"}, int'(dead), e.dd);
        end
    endtask

    function automatic int x_adv(input int x);
        return (x + 2 > 620) ? 0 : x + 2;
    endfunction

    // One frame tick with optional coincident press/collide.
    task automatic step(input bit prs, input bit col, input string tag);
        bit pend;
        int yn;
        pend   = m_pend | prs;
        m_pend = 1'b0;
        case (m_st)
            0: if (pend) m_st = 1;
            1: begin
                if (col) m_st = 3;
                else begin
                    m_x = x_adv(m_x);
                    if (pend) begin
                        m_st = 2;
                        m_v  = 12;
                    end
                end
            end
            2: begin
                if (col) m_st = 3;
                else begin
                    m_x = x_adv(m_x);
                    yn  = m_y - m_v;
                    if (yn >= 220) begin
                        m_y = 220; m_v = 0; m_st = 1; m_used = 1'b0;
                    end else begin
                        if (yn < 0) begin
                            m_y = 0; m_v = 0;
                        end else begin
                            m_y = yn;
                            m_v = (m_v - 1 < -12) ? -12 : m_v - 1;
                        end
`ifdef DOUBLE_JUMP_EN
                        if (pend && !m_used) begin
                            m_v = 12; m_used = 1'b1;
                        end
`endif
                    end
                end
            end
            default: begin
                if (pend) begin
                    m_st = 0; m_x = 0; m_y = 220; m_v = 0; m_used = 1'b0;
                end
            end
        endcase
        push_model(tag);
        @(negedge clk);
        jump_key   = prs;
        collide    = col;
        frame_tick = 1'b1;
        @(negedge clk);
        jump_key   = 1'b0;
        collide    = 1'b0;
        frame_tick = 1'b0;
        compare_out();
    endtask

    task automatic press_only();
        @(negedge clk);
        jump_key = 1'b1;
        @(negedge clk);
        jump_key = 1'b0;
        m_pend   = 1'b1;
    endtask

    task automatic hold(input int n, input string tag);
        push_model(tag);
        repeat (n) @(negedge clk);
        compare_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int y_hold, x_hold, n;

        // Reset with frame_tick held high.
        rst = 1'b1; frame_tick = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; frame_tick = 1'b0;
        m_st = 0; m_x = 0; m_y = 220; m_v = 0; m_pend = 1'b0; m_used = 1'b0;
        hold(1, "reset");
        check("reset_y_const", int'(player_y), 220);

        step(1'b0, 1'b0, "idle_no_press");
        step(1'b0, 1'b1, "idle_collide");

        // Press held pending until the next tick.
        press_only();
        hold(3, "idle_pend_hold");
        step(1'b0, 1'b0, "start");
        check("start_state_const", int'(state), 1);
        check("start_x_const", int'(player_x), 0);
        step(1'b0, 1'b0, "scroll1");
        step(1'b0, 1'b0, "scroll2");
        check("scroll2_x_const", int'(player_x), 4);
        hold(4, "run_hold");

        // Full jump arc.
        step(1'b1, 1'b0, "jump");
        check("jump_state_const", int'(state), 2);
        check("jump_y_const", int'(player_y), 220);
        for (int k = 1; k <= 25; k++) begin
            step(1'b0, 1'b0, $sformatf("arc%0d", k));
            if (k == 1)  check("arc1_y_const", int'(player_y), 208);
            if (k == 12) check("arc12_y_const", int'(player_y), 142);
            if (k == 13) check("arc13_y_const", int'(player_y), 142);
            if (k == 14) check("arc14_y_const", int'(player_y), 143);
            if (k == 25) begin
                check("arc25_y_const", int'(player_y), 220);
                check("arc25_state_const", int'(state), 1);
            end
        end
        step(1'b0, 1'b0, "after_land");

        // Scroll to the right edge, then wrap.
        n = 0;
        while (m_x != 620 && n < 400) begin
            step(1'b0, 1'b0, "to_edge");
            n++;
        end
        check("edge_x_const", int'(player_x), 620);
        step(1'b0, 1'b0, "wrap");
        check("wrap_x_const", int'(player_x), 0);

        // Collision while running, then restart.
        step(1'b0, 1'b0, "pre_col1");
        step(1'b0, 1'b0, "pre_col2");
        step(1'b0, 1'b1, "run_collide");
        check("run_collide_dead_const", int'(dead), 1);
        check("run_collide_x_const", int'(player_x), 4);
        hold(3, "dead_hold");
        step(1'b0, 1'b1, "dead_collide");
        step(1'b1, 1'b0, "restart");
        check("restart_x_const", int'(player_x), 0);
        check("restart_y_const", int'(player_y), 220);

        // Collision beats a coincident press in AIR.
        step(1'b1, 1'b0, "run2");
        step(1'b1, 1'b0, "jump2");
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, $sformatf("air2_%0d", k));
        y_hold = int'(player_y);
        x_hold = int'(player_x);
        step(1'b1, 1'b1, "air_collide_press");
        check("air_collide_state", int'(state), 3);
        check("air_collide_y_frozen", int'(player_y), y_hold);
        check("air_collide_x_frozen", int'(player_x), x_hold);
        press_only();
        step(1'b0, 1'b0, "restart2");
        check("restart2_state_const", int'(state), 0);

        // Mid-air presses.
        step(1'b1, 1'b0, "run3");
        step(1'b1, 1'b0, "jump3");
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, $sformatf("air3_%0d", k));
        step(1'b1, 1'b0, "air3_5_press");
        check("air3_5_y_const", int'(player_y), 170);
        step(1'b0, 1'b0, "air3_6");
`ifdef DOUBLE_JUMP_EN
        check("air3_6_y_const", int'(player_y), 158);
`else
        check("air3_6_y_const", int'(player_y), 163);
`endif
        step(1'b0, 1'b0, "air3_7");
        step(1'b1, 1'b0, "air3_8_press");
        n = 0;
        while (m_st == 2 && n < 80) begin
            step(1'b0, 1'b0, "air3_fall");
            n++;
        end
        check("air3_landed_state", int'(state), 1);
        step(1'b0, 1'b0, "run_after_land");

        // Re-armed after landing.
        step(1'b1, 1'b0, "jump4");
        step(1'b0, 1'b0, "air4_1");
        step(1'b0, 1'b0, "air4_2");
        step(1'b1, 1'b0, "air4_3_press");
        check("air4_3_y_const", int'(player_y), 187);
        step(1'b0, 1'b0, "air4_4");
`ifdef DOUBLE_JUMP_EN
        check("air4_4_y_const", int'(player_y), 175);
`else
        check("air4_4_y_const", int'(player_y), 178);
`endif
        n = 0;
        while (m_st == 2 && n < 80) begin
            step(1'b0, 1'b0, "air4_fall");
            n++;
        end
        check("air4_landed_state", int'(state), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
